// File: rtl/int_log_ctrl.sv
// Command front-end for the 64-bit logic unit int_log. It issues one command at a time,
// captures the result two cycles after acceptance and queues it, tagged, in a fall-through FIFO.
module int_log_ctrl #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_opa,
    input  logic [WIDTH-1:0]         cmd_opb,
    output logic [2:0]               lu_operation,
    output logic [WIDTH-1:0]         lu_opa,
    output logic [WIDTH-1:0]         lu_opb,
    input  logic [WIDTH-1:0]         lu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE    = 1;
    localparam logic [AW-1:0]    PTR_ONE    = 1;
    localparam logic [TAG_W-1:0] TAG_ONE    = 1;
    localparam logic [2:0]       OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t           state;
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] cur_tag;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [DEPTH-1:0] err_mem;
    logic             accept;
    logic             push;
    logic             pop;

    // Handshake: a command moves when cmd_valid && cmd_ready at a rising edge; a result
    // leaves when res_valid && res_ready. Only one command is in flight, so a push never overflows.
    assign cmd_ready = (state == IDLE) && (fifo_count != FULL_COUNT);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state == CAPTURE);
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid && res_ready;
    assign busy      = (state != IDLE);

    assign res_data  = data_mem[rd_ptr];
    assign res_tag   = tag_mem[rd_ptr];
    assign res_err   = err_mem[rd_ptr];

    // lu_* operands stay put until the next accept so int_log always sees stable inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lu_operation <= 3'b000;
            lu_opa       <= '0;
            lu_opb       <= '0;
            tag_cnt      <= '0;
            cur_tag      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lu_operation <= cmd_op;
                        lu_opa       <= cmd_opa;
                        lu_opb       <= cmd_opb;
                        cur_tag      <= tag_cnt;
                        tag_cnt      <= tag_cnt + TAG_ONE;
                        state        <= ISSUE;
                    end
                end
                ISSUE:   state <= CAPTURE;
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Illegal opcode: the unit's output is meaningless, so store zero and flag it instead.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= (lu_operation == OP_ILLEGAL) ? '0 : lu_out;
            tag_mem[wr_ptr]  <= cur_tag;
            err_mem[wr_ptr]  <= (lu_operation == OP_ILLEGAL);
        end
    end

endmodule

// File: tb/tb_int_log_ctrl.sv
// Bench for int_log_ctrl: directed vector table, hand-written corner sequences and a
// randomized phase, all checked against a transaction-level model of the controller.
module tb_int_log_ctrl;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int EW    = WIDTH + TAG_W + 1;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_opa;
    logic [WIDTH-1:0] cmd_opb;
    logic [2:0]       lu_operation;
    logic [WIDTH-1:0] lu_opa;
    logic [WIDTH-1:0] lu_opb;
    logic [WIDTH-1:0] lu_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             busy;
    logic [2:0]       fifo_count;

    logic [WIDTH-1:0] junk;
    logic [WIDTH-1:0] stub_base;

    int errors = 0;
    int checks = 0;

    int_log_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
        .lu_operation(lu_operation), .lu_opa(lu_opa), .lu_opb(lu_opb), .lu_out(lu_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err), .busy(busy), .fifo_count(fifo_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Stand-in for int_log; drives garbage on the illegal opcode so the controller must ignore it.
    always_comb begin
        case (lu_operation[2:1])
            2'b00:   stub_base = lu_opa & lu_opb;
            2'b01:   stub_base = lu_opa | lu_opb;
            2'b10:   stub_base = lu_opa ^ lu_opb;
            default: stub_base = ~lu_opa;
        endcase
        if (lu_operation == 3'b111)  lu_out = junk;
        else if (lu_operation[0])    lu_out = ~stub_base;
        else                         lu_out = stub_base;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return '0;
        endcase
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    pending;
    logic [EW-1:0]    head;
    int               phase;
    logic             m_ready;
    logic [TAG_W-1:0] m_tag;
    logic [2:0]       m_op;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            phase = 0;
            m_tag = '0;
            m_op  = '0;
            m_a   = '0;
            m_b   = '0;
        end else begin
            m_ready = (phase == 0) && (exp_q.size() < DEPTH);
            check("cmd_ready", 64'(cmd_ready), 64'(m_ready));
            check("busy", 64'(busy), 64'(phase != 0));
            check("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
            check("res_valid", 64'(res_valid), 64'(exp_q.size() != 0));
            check("lu_operation", 64'(lu_operation), 64'(m_op));
            check("lu_opa", lu_opa, m_a);
            check("lu_opb", lu_opb, m_b);
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check("res_data", res_data, head[WIDTH-1:0]);
                check("res_tag", 64'(res_tag), 64'(head[WIDTH+TAG_W-1:WIDTH]));
                check("res_err", 64'(res_err), 64'(head[EW-1]));
            end
            // advance the model to the next rising edge
            if (exp_q.size() != 0 && res_ready) void'(exp_q.pop_front());
            if (phase == 2) begin
                exp_q.push_back(pending);
                phase = 0;
            end else if (phase == 1) begin
                phase = 2;
            end else if (cmd_valid && m_ready) begin
                pending = {cmd_op == 3'b111, m_tag, ref_op(cmd_op, cmd_opa, cmd_opb)};
                m_tag   = m_tag + 1'b1;
                m_op    = cmd_op;
                m_a     = cmd_opa;
                m_b     = cmd_opb;
                phase   = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        cmd_op    = op;
        cmd_opa   = a;
        cmd_opb   = b;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                cmd_opa   = {$urandom(), $urandom()};
                cmd_opb   = {$urandom(), $urandom()};
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: cmd_ready stayed 0 for 100 cycles, required 1");
        cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_data;
        logic [TAG_W-1:0] exp_tag;
        logic             exp_err;
    } vec_t;

    vec_t vecs[10];

    // ---------------- main sequence ----------------
    initial begin
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        pa = {8{8'hA5}};
        pb = {8{8'h0F}};
        vecs[0] = '{3'b000, 64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00,
                    64'hFF00_0000_FF00_0000, 4'd0, 1'b0};
        vecs[1] = '{3'b000, pa, pb, {8{8'h05}}, 4'd1, 1'b0};
        vecs[2] = '{3'b001, pa, pb, {8{8'hFA}}, 4'd2, 1'b0};
        vecs[3] = '{3'b010, pa, pb, {8{8'hAF}}, 4'd3, 1'b0};
        vecs[4] = '{3'b011, pa, pb, {8{8'h50}}, 4'd4, 1'b0};
        vecs[5] = '{3'b100, pa, pb, {8{8'hAA}}, 4'd5, 1'b0};
        vecs[6] = '{3'b101, pa, pb, {8{8'h55}}, 4'd6, 1'b0};
        vecs[7] = '{3'b110, pa, pb, {8{8'h5A}}, 4'd7, 1'b0};
        vecs[8] = '{3'b010, pa, pb, {8{8'hAF}}, 4'd8, 1'b0};
        vecs[9] = '{3'b111, pa, pb, 64'h0,      4'd9, 1'b1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_opa = '0; cmd_opb = '0;
        res_ready = 1'b1; junk = 64'hDEAD_BEEF_CAFE_F00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_fifo_count", 64'(fifo_count), 64'(0));
        check("reset_res_valid", 64'(res_valid), 64'(1'b0));
        check("reset_lu_opa", lu_opa, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(1);

        // directed vectors: result appears exactly two cycles after acceptance
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            check("vec_valid_k0", 64'(res_valid), 64'(1'b0));
            @(negedge clk);
            check("vec_valid_k1", 64'(res_valid), 64'(1'b0));
            @(negedge clk);
            check("vec_valid_k2", 64'(res_valid), 64'(1'b1));
            check("vec_data", res_data, vecs[i].exp_data);
            check("vec_tag", 64'(res_tag), 64'(vecs[i].exp_tag));
            check("vec_err", 64'(res_err), 64'(vecs[i].exp_err));
            @(posedge clk); #1;
        end

        // backpressure: four fill the FIFO, the fifth waits for one pop
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'($urandom_range(0, 7)), {$urandom(), $urandom()}, {$urandom(), $urandom()});
        cmd_op = 3'b100; cmd_opa = {$urandom(), $urandom()}; cmd_opb = {$urandom(), $urandom()};
        cmd_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_full_count", 64'(fifo_count), 64'(4));
        check("bp_full_ready", 64'(cmd_ready), 64'(1'b0));
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_pop", 64'(cmd_ready), 64'(1'b1));
        check("bp_count_after_pop", 64'(fifo_count), 64'(3));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        idle_cycles(3);
        check("bp_refilled", 64'(fifo_count), 64'(4));
        res_ready = 1'b1;
        idle_cycles(8);

        // reset while CAPTURE is pending with two entries queued
        res_ready = 1'b0;
        send(3'b000, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        idle_cycles(2);
        send(3'b010, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        idle_cycles(2);
        send(3'b100, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        @(posedge clk);
        #2;
        check("pre_rst_count", 64'(fifo_count), 64'(2));
        check("pre_rst_busy", 64'(busy), 64'(1'b1));
        rst = 1'b1;
        #1;
        check("mid_rst_res_valid", 64'(res_valid), 64'(1'b0));
        check("mid_rst_fifo_count", 64'(fifo_count), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        send(3'b101, {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (3) @(negedge clk);
        check("post_rst_valid", 64'(res_valid), 64'(1'b1));
        check("post_rst_tag", 64'(res_tag), 64'(0));
        @(posedge clk); #1;

        // tag wrap: 19 more commands, the last carries tag 3
        for (int i = 0; i < 19; i++) send(3'($urandom_range(0, 7)), {$urandom(), $urandom()}, {$urandom(), $urandom()});
        repeat (3) @(negedge clk);
        check("wrap_last_tag", 64'(res_tag), 64'(3));
        @(posedge clk); #1;

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_opa   = {$urandom(), $urandom()};
            cmd_opb   = {$urandom(), $urandom()};
            res_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : (c % 100 < 60 ? 1'b1 : 1'b0);
            junk      = {$urandom(), $urandom()};
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        idle_cycles(20);
        check("drain_empty", 64'(fifo_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
